// File: rtl/timer_irq_ctrl_if.sv
// Register bus shared with the upstream timer: 6-bit address, 8-bit data window access.
interface timer_irq_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              mod_en;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output wr_en, output mod_en, output wdata, input  rdata);
    modport slave  (input  addr, input  wr_en, input  mod_en, input  wdata, output rdata);
endinterface

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt aggregator: sticky W1C status, mask/priority, hold-off gap between IRQs.
// Optional per-source event counters at offsets 5-7 when IRQ_EVENT_CNT_EN is defined.
module timer_irq_ctrl #(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 6'h20
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    timer_irq_ctrl_if.slave      bus,
    input  logic                 i_overflow_int,
    input  logic                 i_comp_0_match_int,
    input  logic                 i_comp_1_match_int,
    output logic                 o_irq_out,
    output logic [1:0]           o_irq_id
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ASSERT = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [2:0]        w_src, w_rise, w_w1c, w_active;
    logic              w_hit, w_wr, w_any;
    logic [2:0]        w_off;
    logic [1:0]        w_id_nxt;
    logic [DATA_W-1:0] w_rdata;

    logic [2:0]        r_prev, r_status, r_mask;
    logic              r_gen, r_irq;
    logic [DATA_W-1:0] r_holdoff, r_cnt;
    logic [1:0]        r_state, r_id;

    assign w_src    = {i_comp_1_match_int, i_comp_0_match_int, i_overflow_int};
    assign w_rise   = w_src & ~r_prev;
    assign w_hit    = bus.mod_en && (bus.addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    assign w_wr     = w_hit && bus.wr_en;
    assign w_off    = bus.addr[2:0];
    assign w_w1c    = (w_wr && w_off == 3'd0) ? bus.wdata[2:0] : 3'b000;
    assign w_active = r_status & r_mask & {3{r_gen}};
    assign w_any    = |w_active;

    always_comb begin
        w_id_nxt = 2'd3;
        if      (w_active[0]) w_id_nxt = 2'd0;
        else if (w_active[1]) w_id_nxt = 2'd1;
        else if (w_active[2]) w_id_nxt = 2'd2;
    end

    // OR-ing the rise after the clear makes a same-cycle set win over W1C.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev    <= '0;
            r_status  <= '0;
            r_mask    <= '0;
            r_gen     <= 1'b0;
            r_holdoff <= '0;
            r_id      <= 2'd3;
        end else begin
            r_prev   <= w_src;
            r_status <= (r_status & ~w_w1c) | w_rise;
            r_id     <= w_id_nxt;
            if (w_wr && w_off == 3'd1) r_mask    <= bus.wdata[2:0];
            if (w_wr && w_off == 3'd2) r_gen     <= bus.wdata[0];
            if (w_wr && w_off == 3'd4) r_holdoff <= bus.wdata;
        end
    end

    // Hold-off: cnt loaded with HOLDOFF on exit from ASSERT; IDLE on the edge cnt hits 0,
    // giving HOLDOFF+1 low cycles before the next possible assertion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_ASSERT;
                        r_irq   <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (!w_any) begin
                        r_irq <= 1'b0;
                        if (r_holdoff != '0) begin
                            r_state <= S_HOLD;
                            r_cnt   <= r_holdoff;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == DATA_W'(1)) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_EVENT_CNT_EN
    logic [2:0][7:0] r_evcnt;

    // A clearing write still counts a rise landing in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_evcnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_wr && w_off == 3'(5 + i))
                    r_evcnt[i] <= w_rise[i] ? 8'd1 : 8'd0;
                else if (w_rise[i] && r_evcnt[i] != 8'hFF)
                    r_evcnt[i] <= r_evcnt[i] + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                3'd0: w_rdata[2:0] = r_status;
                3'd1: w_rdata[2:0] = r_mask;
                3'd2: w_rdata[0]   = r_gen;
                3'd3: w_rdata[1:0] = r_id;
                3'd4: w_rdata      = r_holdoff;
`ifdef IRQ_EVENT_CNT_EN
                3'd5: w_rdata      = DATA_W'(r_evcnt[0]);
                3'd6: w_rdata      = DATA_W'(r_evcnt[1]);
                3'd7: w_rdata      = DATA_W'(r_evcnt[2]);
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata = w_rdata;
    assign o_irq_out = r_irq;
    assign o_irq_id  = r_id;
endmodule
